mac_accum: RTL and testbench

Dot-product accumulator that sits directly downstream of the buffer-fed single multiplier in the CNN datapath. It consumes a stream of signed products, sums a programmed number of them onto a bias in a guard-extended accumulator, then applies optional ReLU and saturation. The finished result is presented on a valid/ready output port for the next layer stage or write-back logic.

---
 rtl/mac_accum_pkg.sv | 24 ++
 rtl/mac_accum_sat_relu.sv | 36 +++
 rtl/mac_accum.sv | 134 +++++++++++++
 tb/tb_mac_accum.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pkg.sv
// Shared definitions for the MAC accumulator and its post-processing stages.
// Includes the state encoding and the saturation limits derived from a data width.
package mac_accum_pkg;

    typedef enum logic [1:0] {
        MACC_IDLE  = 2'd0,
        MACC_ACCUM = 2'd1,
        MACC_OUT   = 2'd2
    } macc_state_t;

    localparam int unsigned MACC_DATA_WID = 16;
    localparam int unsigned MACC_GUARD_B  = 8;
    localparam int unsigned MACC_LEN_B    = 8;

    // Signed saturation bounds for a w-bit result, usable in constant expressions.
    function automatic longint sat_max_of(input int unsigned w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min_of(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/mac_accum_sat_relu.sv
// Combinational post-processing: saturate a guarded accumulator value to
// DATA_WID bits, then optionally clamp negative results to zero.
module sat_relu
    import mac_accum_pkg::*;
#(
    parameter int unsigned DATA_WID = MACC_DATA_WID,
    parameter int unsigned GUARD_B  = MACC_GUARD_B
) (
    input  logic signed [DATA_WID+GUARD_B-1:0] acc_in,
    input  logic                               relu_en,
    output logic        [DATA_WID-1:0]         result
);

    localparam int unsigned ACC_W = DATA_WID + GUARD_B;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max_of(DATA_WID));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min_of(DATA_WID));

    logic [DATA_WID-1:0] sat_val;

    always_comb begin
        sat_val = acc_in[DATA_WID-1:0];
        if (acc_in > SAT_HI) begin
            sat_val = SAT_HI[DATA_WID-1:0];
        end else if (acc_in < SAT_LO) begin
            sat_val = SAT_LO[DATA_WID-1:0];
        end
    end

    always_comb begin
        result = sat_val;
        if (relu_en && sat_val[DATA_WID-1]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Dot-product accumulator: sums len signed products onto a bias in a guarded
// accumulator, then saturates / ReLUs and presents the result on valid/ready.
module mac_accum
    import mac_accum_pkg::*;
#(
    parameter int unsigned DATA_WID = MACC_DATA_WID,
    parameter int unsigned GUARD_B  = MACC_GUARD_B,
    parameter int unsigned LEN_B    = MACC_LEN_B
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic        [LEN_B-1:0]    len,
    input  logic signed [DATA_WID-1:0] bias,
    input  logic                       relu_en,
    input  logic                       in_valid,
    input  logic signed [DATA_WID-1:0] in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic        [DATA_WID-1:0] out_data,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int unsigned ACC_W = DATA_WID + GUARD_B;

    macc_state_t state, state_nxt;

    logic signed [ACC_W-1:0]    acc;
    logic        [LEN_B-1:0]    cnt;
    logic                       relu_q;

    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    data_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    sat_in;
    logic                       sat_relu_en;
    logic        [DATA_WID-1:0] post;
    logic                       take;
    logic                       last;

    assign bias_ext = {{GUARD_B{bias[DATA_WID-1]}}, bias};
    assign data_ext = {{GUARD_B{in_data[DATA_WID-1]}}, in_data};
    assign sum      = acc + data_ext;
    assign take     = (state == MACC_ACCUM) && in_valid;
    assign last     = take && (cnt == LEN_B'(1));

    // One post-processing instance serves both the len==0 path (bias with the
    // incoming relu_en, not yet latched) and the final-product path.
    always_comb begin
        sat_in      = sum;
        sat_relu_en = relu_q;
        if (state == MACC_IDLE) begin
            sat_in      = bias_ext;
            sat_relu_en = relu_en;
        end
    end

    sat_relu #(
        .DATA_WID (DATA_WID),
        .GUARD_B  (GUARD_B)
    ) u_sat_relu (
        .acc_in  (sat_in),
        .relu_en (sat_relu_en),
        .result  (post)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MACC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MACC_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? MACC_OUT : MACC_ACCUM;
                end
            end
            MACC_ACCUM: begin
                if (last) begin
                    state_nxt = MACC_OUT;
                end
            end
            MACC_OUT: begin
                if (out_ready) begin
                    state_nxt = MACC_IDLE;
                end
            end
            default: state_nxt = MACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            relu_q   <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                MACC_IDLE: begin
                    if (start) begin
                        acc    <= bias_ext;
                        cnt    <= len;
                        relu_q <= relu_en;
                        if (len == '0) begin
                            out_data <= post;
                        end
                    end
                end
                MACC_ACCUM: begin
                    if (take) begin
                        acc <= sum;
                        cnt <= cnt - LEN_B'(1);
                        if (last) begin
                            out_data <= post;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == MACC_ACCUM);
    assign out_valid = (state == MACC_OUT);
    assign busy      = (state != MACC_IDLE);

endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (DATA_WID=16, GUARD_B=8).
module tb_mac_accum;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic        [7:0]  len;
    logic signed [15:0] bias;
    logic               relu_en;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic        [15:0] out_data;
    logic               out_ready;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_accum #(
        .DATA_WID (16),
        .GUARD_B  (8),
        .LEN_B    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int res();
        return int'($signed(out_data));
    endfunction

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int l, input int b, input logic r);
        start   = 1'b1;
        len     = 8'(l);
        bias    = 16'(b);
        relu_en = r;
        tick();
        start   = 1'b0;
        len     = '0;
        bias    = '0;
        relu_en = 1'b0;
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1;
        in_data  = 16'(v);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, int'(out_valid), 0);
        check({tag, "_busy_after_hs"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", res(), 0);
        check("rst_busy", int'(busy), 0);

        // Basic sum: 10 + 5 - 2 + 7 = 20
        start_op(3, 10, 1'b0);
        check("basic_busy", int'(busy), 1);
        check("basic_in_ready", int'(in_ready), 1);
        feed(5); feed(-2);
        check("basic_no_early_valid", int'(out_valid), 0);
        feed(7);
        check("basic_valid", int'(out_valid), 1);
        check("basic_data", res(), 20);
        check("basic_in_ready_out", int'(in_ready), 0);
        handshake("basic");

        // Gaps and backpressure
        start_op(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            feed(1);
            if (i < 3) begin
                tick();
                check("gap_hold_in_ready", int'(in_ready), 1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", res(), 4);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        check("bp_valid_end", int'(out_valid), 1);
        check("bp_data_end", res(), 4);
        handshake("bp");

        // Saturation and ReLU
        start_op(2, 0, 1'b0);
        feed(30000); feed(30000);
        check("sat_pos", res(), 32767);
        handshake("sat_pos");
        start_op(2, 0, 1'b0);
        feed(-30000); feed(-30000);
        check("sat_neg", res(), -32768);
        handshake("sat_neg");
        start_op(2, 0, 1'b1);
        feed(-30000); feed(-30000);
        check("sat_neg_relu", res(), 0);
        handshake("sat_neg_relu");

        // len == 0 with ReLU; a product offered during OUT must not be consumed
        start_op(0, -5, 1'b1);
        check("len0_valid", int'(out_valid), 1);
        check("len0_data", res(), 0);
        check("len0_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_data = 16'(100);
        tick();
        in_valid = 1'b0; in_data = '0;
        check("len0_data_hold", res(), 0);
        handshake("len0");
        start_op(0, -5, 1'b0);
        check("len0_norelu_data", res(), -5);
        handshake("len0_norelu");

        // Ignored start during ACCUM/OUT, ignored in_valid during OUT/IDLE
        start_op(2, 1, 1'b0);
        feed(2);
        start = 1'b1; len = 8'd7; bias = 16'(100); relu_en = 1'b1;
        tick();
        start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
        check("ign_accum_in_ready", int'(in_ready), 1);
        check("ign_accum_no_valid", int'(out_valid), 0);
        feed(3);
        check("ign_accum_data", res(), 6);
        start = 1'b1; len = 8'd3; bias = 16'(-50);
        in_valid = 1'b1; in_data = 16'(50);
        tick();
        start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_data = '0;
        check("ign_out_valid", int'(out_valid), 1);
        check("ign_out_data", res(), 6);
        handshake("ign");
        in_valid = 1'b1; in_data = 16'(77);
        tick();
        in_valid = 1'b0; in_data = '0;
        check("ign_idle_in_ready", int'(in_ready), 0);
        check("ign_idle_busy", int'(busy), 0);
        start_op(1, 0, 1'b0);
        feed(9);
        check("ign_next_sum", res(), 9);
        handshake("ign_next");

        // Reset mid-operation
        start_op(5, 0, 1'b0);
        feed(1); feed(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_in_ready", int'(in_ready), 0);
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_out_data", res(), 0);
        check("rst_mid_busy", int'(busy), 0);
        start_op(1, 3, 1'b0);
        feed(4);
        check("rst_new_valid", int'(out_valid), 1);
        check("rst_new_data", res(), 7);
        handshake("rst_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
